// File: rtl/busint_pkg.sv
// Shared definitions for the busint memory request/acknowledge protocol.
package busint_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_REARM
    } state_t;

endpackage

// File: rtl/busint_resp_ram.sv
// Single-port word RAM with registered read and no reset; contents survive bus reset.
module busint_resp_ram
    import busint_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/busint_test_responder.sv
// Bus-target test model: acknowledges memrq/memwr requests, backs one address
// window with a word RAM, returns read data with memdone, and counts traffic.
module busint_test_responder
    import busint_pkg::*;
#(
    parameter int                 AW        = 8,
    parameter logic [ADDR_W-1:0]  BASE      = 22'o00100000,
    parameter int                 LATENCY   = 4,
    parameter logic [DATA_W-1:0]  MISS_DATA = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memrq,
    input  logic              memwr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] busout,
    output logic              memack,
    output logic              memdone,
    output logic [DATA_W-1:0] busin,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              miss,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        ack_cnt, ack_cnt_next;
    logic              done_next;
    logic [AW-1:0]     cap_addr;
    logic              cap_wr;
    logic              cap_hit;
    logic              memack_q, memdone_q, miss_q;
    logic [15:0]       rd_count_q, wr_count_q;
    logic              hit, accept;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign hit    = (addr[ADDR_W-1:AW] == BASE[ADDR_W-1:AW]);
    assign accept = (state == S_IDLE) && memrq;

    // The RAM reads the live address on the accepting edge and the captured
    // address afterwards, so data is ready even when LATENCY is 1.
    assign ram_addr = (state == S_IDLE) ? addr[AW-1:0] : cap_addr;

    busint_resp_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (accept && memwr && hit),
        .addr  (ram_addr),
        .wdata (busout),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next   = state;
        ack_cnt_next = ack_cnt;
        done_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (memrq) begin
                    state_next   = S_ACK;
                    ack_cnt_next = LAT_M1;
                    done_next    = !memwr && (LATENCY == 1);
                end
            end
            S_ACK: begin
                if (ack_cnt != 4'd0) begin
                    ack_cnt_next = 4'(ack_cnt - 4'd1);
                    done_next    = (ack_cnt == 4'd1) && !cap_wr;
                end else begin
                    state_next = memrq ? S_REARM : S_IDLE;
                end
            end
            S_REARM: begin
                if (!memrq) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ack_cnt    <= 4'd0;
            cap_addr   <= '0;
            cap_wr     <= 1'b0;
            cap_hit    <= 1'b0;
            memack_q   <= 1'b0;
            memdone_q  <= 1'b0;
            miss_q     <= 1'b0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state     <= state_next;
            ack_cnt   <= ack_cnt_next;
            memack_q  <= (state_next == S_ACK);
            memdone_q <= done_next;
            if (accept) begin
                cap_addr <= addr[AW-1:0];
                cap_wr   <= memwr;
                cap_hit  <= hit;
                if (memwr) begin
                    wr_count_q <= 16'(wr_count_q + 16'd1);
                end else begin
                    rd_count_q <= 16'(rd_count_q + 16'd1);
                end
                if (!hit) begin
                    miss_q <= 1'b1;
                end
            end
        end
    end

    // busin is forced to zero outside the memdone cycle because the
    // initiator treats any memdone as a load of busin.
    assign busin    = memdone_q ? (cap_hit ? ram_rdata : MISS_DATA) : '0;
    assign memack   = memack_q;
    assign memdone  = memdone_q;
    assign miss     = miss_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign busy     = (state != S_IDLE);

endmodule

// File: doc/busint_test_responder.md
# busint_test_responder

Bus-target model for the busint memory request/acknowledge protocol. Answers `memrq`/`memwr` requests from a bus initiator such as the microcoded peripheral test CPU. Backs a window of bus addresses with a small word RAM and returns read data with a `memdone` strobe. Used in place of real memory/peripherals in test builds, and keeps request and miss statistics for the bench.

## Interface
Parameters:
- `AW`, 8: RAM address width; RAM holds 2^AW 32-bit words.
- `BASE`, 22'o00100000: window base. A request hits when `addr[21:AW] == BASE[21:AW]`.
- `LATENCY`, 4: number of cycles `memack` is held high per request. Legal range 1..15.
- `MISS_DATA`, 32'h0: data returned for reads outside the window.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `memrq`  in  1  request from initiator. Level; may stay high one cycle past `memack`.
- `memwr`  in  1  write qualifier. Valid whenever `memrq` is high.
- `addr`  in  22  word address. Valid while `memrq` is high.
- `busout`  in  32  write data from initiator. Valid while `memrq` is high.
- `memack`  out  1  acknowledge. Reset 0.
- `memdone`  out  1  one-cycle read-data strobe. Reset 0.
- `busin`  out  32  read data. Nonzero only in the `memdone` cycle. Reset 0.
- `rd_count`  out  16  accepted reads, wraps at 16'hffff→0. Reset 0.
- `wr_count`  out  16  accepted writes, wraps. Reset 0.
- `miss`  out  1  sticky: some request fell outside the window. Reset 0.
- `busy`  out  1  high whenever state is not IDLE. Reset 0.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - ACK: acknowledging; down-counter `ack_cnt` (4 bits) running.
  - REARM: waiting for the initiator to drop `memrq`.
- Transitions:
  - IDLE & `memrq` → ACK. Load `ack_cnt` = LATENCY-1. Capture `addr`, `memwr`, hit flag.
  - ACK & `ack_cnt` != 0 → ACK, decrementing `ack_cnt`.
  - ACK & `ack_cnt` == 0 → IDLE if `memrq` is low, else REARM.
  - REARM & ~`memrq` → IDLE.
- IDLE must see `memrq` low then high before it accepts again. A held `memrq` is never accepted twice.
- Writes:
  - Hit: RAM[`addr[AW-1:0]`] ← `busout` on the accepting edge.
  - Miss: data discarded, `miss` set.
  - `wr_count` increments on the accepting edge in both cases.
  - No `memdone` for writes, because the initiator latches `busin` on any `memdone`.
- Reads:
  - Hit: RAM read from the captured address.
  - Miss: returns `MISS_DATA` and sets `miss`.
  - `rd_count` increments on the accepting edge.
- `memack` = registered (state == ACK).
- `memdone` and `busin` are registered outputs. They are asserted only in the final `memack` cycle of a read.
- Reset at any point, including mid-ACK:
  - All outputs go to 0 and the state goes to IDLE next cycle.
  - RAM contents are not cleared.
  - A partially acknowledged request is abandoned.

## Timing
- `memrq` is sampled high in IDLE at cycle t.
- `memack` is high for cycles t+1 .. t+LATENCY and low at t+LATENCY+1.
- Reads: `memdone` = 1 and `busin` = data only at cycle t+LATENCY. Data is therefore latched by the initiator before it sees `memack` fall.
- With LATENCY=1, `memack` and `memdone` share the single cycle t+1.
- A write at t is readable by a request accepted at t+LATENCY+1 or later. No bypass is needed.
- Minimum request spacing is LATENCY+1 cycles, or more if `memrq` is held (REARM).
- `busy` is combinational from state: 1 from cycle t+1 until return to IDLE.

## Structure
- Shared package `busint_pkg`:
  - `ADDR_W`=22, `DATA_W`=32.
  - State enum {S_IDLE, S_ACK, S_REARM}.
- Sub-module `busint_resp_ram`: single-port synchronous RAM, 2^AW×32. Write enable, registered read, no reset.
- Top module: FSM, capture registers, hit decode, counters, output registers.

## Test plan
- Write 32'hcafe0001 to 22'o00100005, then read the same address → `memack` high exactly 4 cycles each. Read gives `memdone` in the 4th `memack` cycle with `busin`=32'hcafe0001. No `memdone` on the write.
- LATENCY=1 read of an unwritten-then-written word (value 32'h12345678) → `memack` and `memdone` coincide for one cycle with the correct data.
- Hold `memrq` high for 10 cycles → exactly one acceptance: `rd_count`=1, FSM in REARM until `memrq` falls, then IDLE.
- Read 22'o17377770 (outside window) → `busin`=MISS_DATA in the `memdone` cycle, `miss`=1 and stays 1 after later hits.
- Assert `reset` at the 2nd `memack` cycle of a read → next cycle `memack`=`memdone`=`busy`=0, counters 0. A following read of a previously written address still returns the stored value.
- 65536 reads back-to-back → `rd_count` wraps to 0; `wr_count` unchanged.
